req_grant_arbiter: RTL

//   Round-robin arbiter that shares a single resource between N requesters

---
 rtl/req_grant_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/req_grant_arbiter.sv
// req_grant_arbiter: round-robin level request/grant arbiter with bounded hold time
module req_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N),
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    request,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            timeout_pulse
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t          state;
  logic [CNT_W-1:0] hold_cnt;
  logic [N-1:0]    blocked, elig;
  logic [ID_W-1:0] ptr, pick, pick_nxt;
  logic            found;
  assign elig        = request & ~blocked;
  assign grant_valid = |grant;
  assign pick_nxt    = (int'(pick) == N - 1) ? '0 : pick + ID_W'(1);
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && elig[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        pick  = ID_W'((int'(ptr) + k) % N);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      grant_id      <= '0;
      timeout_pulse <= 1'b0;
      hold_cnt      <= '0;
      blocked       <= '0;
      ptr           <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      // a requester is unblocked as soon as it is seen low
      blocked       <= blocked & request;
      case (state)
        IDLE, RELEASE: begin
          if (found) begin
            state    <= GRANT;
            grant    <= {{(N-1){1'b0}}, 1'b1} << pick;
            grant_id <= pick;
            hold_cnt <= CNT_W'(1);
            ptr      <= pick_nxt;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!request[grant_id]) begin
            state <= RELEASE;
            grant <= '0;
          end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
            state             <= RELEASE;
            grant             <= '0;
            timeout_pulse     <= 1'b1;
            blocked[grant_id] <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
